// File: rtl/serial_src_pkg.sv
// Shared definitions for the serial pattern source: state encoding and
// helpers that size the bit and divide counters.
package serial_src_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 1;

  // Bit counter spans 0..WIDTH-1 (WIDTH >= 2, so at least one bit).
  function automatic int bit_cw(input int width);
    return $clog2(width);
  endfunction

  // Divide counter spans 0..DIV-1; DIV=1 still needs a 1-bit register.
  function automatic int div_cw(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  localparam int BIT_CW_DEF = bit_cw(DEF_WIDTH);
  localparam int DIV_CW_DEF = div_cw(DEF_DIV);

endpackage

// File: rtl/serial_pattern_source_bit_timer.sv
// DIV prescaler: marks the first and last cycle of each serial bit period.
module bit_timer
  import serial_src_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic period_start,
  output logic period_end
);

  localparam int CW = div_cw(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running 0..DIV-1 counter while enabled; clear restarts a period.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign period_start = (cnt == '0);
  assign period_end   = (cnt == LAST);

endmodule

// File: rtl/serial_pattern_source.sv
// Serialises a WIDTH-bit word MSB-first on w, each bit held DIV cycles,
// with a one-cycle done pulse after the last bit.
module serial_pattern_source
  import serial_src_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             w,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int BCW = bit_cw(WIDTH);
  localparam logic [BCW-1:0] BLAST = BCW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [BCW-1:0]   bit_cnt;
  logic             accept, in_shift, p_start, p_end;

  assign in_shift = (state == SHIFT);
  assign accept   = load && (state == IDLE);

  bit_timer #(.DIV(DIV)) u_timer (
    .Clock        (Clock),
    .Reset        (Reset),
    .clr          (accept),
    .en           (in_shift),
    .period_start (p_start),
    .period_end   (p_end)
  );

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and Moore outputs; load only steers the next state.
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    w          = 1'b0;
    bit_strobe = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        w          = sreg[WIDTH-1];
        bit_strobe = p_start;
        if (p_end && (bit_cnt == BLAST)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter: load on accept, advance at period end.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sreg    <= data_in;
      bit_cnt <= '0;
    end else if (in_shift && p_end) begin
      sreg    <= {sreg[WIDTH-2:0], 1'b0};
      bit_cnt <= (bit_cnt == BLAST) ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: one DIV=1 and one DIV=4 instance,
// per-cycle expectations queued from a spec-derived model.
module tb_serial_pattern_source;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data1 = '0, data4 = '0;
  logic       load1 = 1'b0, load4 = 1'b0;
  logic       r1, w1, s1, b1, d1;
  logic       r4, w4, s4, b4, d4;

  typedef struct packed {
    logic w;
    logic s;
    logic b;
    logic d;
    logic r;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    bit         sel4;
    int         exp_done;
  } vec_t;

  obs_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  localparam obs_t IDLE_OBS = '{w:1'b0, s:1'b0, b:1'b0, d:1'b0, r:1'b1};

  always #5 clk = ~clk;

  serial_pattern_source #(.WIDTH(8), .DIV(1)) u_d1 (
    .Clock(clk), .Reset(rst_n), .data_in(data1), .load(load1),
    .ready(r1), .w(w1), .bit_strobe(s1), .busy(b1), .done(d1)
  );

  serial_pattern_source #(.WIDTH(8), .DIV(4)) u_d4 (
    .Clock(clk), .Reset(rst_n), .data_in(data4), .load(load4),
    .ready(r4), .w(w4), .bit_strobe(s4), .busy(b4), .done(d4)
  );

  function automatic obs_t get_obs(input bit sel4);
    obs_t o;
    if (sel4) o = '{w:w4, s:s4, b:b4, d:d4, r:r4};
    else      o = '{w:w1, s:s1, b:b1, d:d1, r:r1};
    return o;
  endfunction

  // Expected outputs in cycle c (1-based) after a load of dat at edge 0.
  function automatic obs_t model(input logic [7:0] dat, input int div, input int c);
    obs_t o;
    int   n;
    n = 8 * div;
    o = IDLE_OBS;
    if (c <= n) begin
      o.w = dat[7 - (c - 1) / div];
      o.s = ((c - 1) % div) == 0;
      o.b = 1'b1;
      o.r = 1'b0;
    end else if (c == n + 1) begin
      o.b = 1'b1;
      o.d = 1'b1;
      o.r = 1'b0;
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input int c, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got wsbdr=%b expected wsbdr=%b", name, c, act, exp);
    end
  endtask

  // Called at a negedge in IDLE. Loads dat, checks every cycle through the
  // following IDLE cycle; inj>0 pulses load with 8'hFF in that cycle.
  task automatic run_frame(input string name, input logic [7:0] dat, input bit sel4,
                           input int inj, output int done_at);
    int   div, n;
    obs_t e;
    div = sel4 ? 4 : 1;
    n = 8 * div;
    done_at = -1;
    for (int c = 1; c <= n + 2; c++) q.push_back(model(dat, div, c));
    if (sel4) begin data4 = dat; load4 = 1'b1; end
    else      begin data1 = dat; load1 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    load1 = 1'b0;
    load4 = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      e = q.pop_front();
      chk_obs(name, c, get_obs(sel4), e);
      if (get_obs(sel4).d && done_at < 0) done_at = c;
      if (c == inj) begin
        data1 = 8'hFF; data4 = 8'hFF;
        if (sel4) load4 = 1'b1; else load1 = 1'b1;
      end else begin
        load1 = 1'b0; load4 = 1'b0;
      end
      if (c < n + 2) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    obs_t e;
    int   dn;

    vecs[0] = '{data:8'hD0, sel4:1'b0, exp_done:9};
    vecs[1] = '{data:8'hA5, sel4:1'b1, exp_done:33};
    vecs[2] = '{data:8'h00, sel4:1'b0, exp_done:9};
    vecs[3] = '{data:8'hFF, sel4:1'b1, exp_done:33};
    vecs[4] = '{data:8'h01, sel4:1'b0, exp_done:9};

    // Reset state.
    #1;
    chk_obs("reset_d1", 0, get_obs(1'b0), IDLE_OBS);
    chk_obs("reset_d4", 0, get_obs(1'b1), IDLE_OBS);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames.
    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].sel4, 0, dn);
      chk($sformatf("vec%0d_done_cycle", i), dn, vecs[i].exp_done);
    end

    // Load while busy is ignored.
    run_frame("ignore_busy", 8'h0F, 1'b0, 3, dn);
    chk("ignore_busy_done_cycle", dn, 9);

    // Reset during SHIFT, then a clean frame.
    data1 = 8'hFF; load1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_reset_pre_w", int'(w1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_obs("mid_reset_d1", 3, get_obs(1'b0), IDLE_OBS);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_obs("after_reset_idle", 0, get_obs(1'b0), IDLE_OBS);
    run_frame("post_reset_80", 8'h80, 1'b0, 0, dn);
    chk("post_reset_done_cycle", dn, 9);

    // load held high: back-to-back frames every 10 cycles.
    for (int f = 0; f < 3; f++)
      for (int c = 1; c <= 10; c++) q.push_back(model(8'hC3, 1, c));
    data1 = 8'hC3; load1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 30; c++) begin
      e = q.pop_front();
      chk_obs("load_tied", c, get_obs(1'b0), e);
      if (c == 30) load1 = 1'b0;
      else @(negedge clk);
    end
    @(negedge clk);
    chk_obs("load_tied_idle", 31, get_obs(1'b0), IDLE_OBS);
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pattern_source.md
# serial_pattern_source

Upstream stimulus stage for the sequence-detector FSM: accepts a WIDTH-bit word through a valid/ready handshake and emits it MSB-first as a one-bit serial stream `w`. Each bit is held for DIV clock cycles. The detector samples `w` directly on the same `Clock`, with no resynchronisation. A one-cycle `done` pulse marks the end of each frame.

## Interface
- `WIDTH`, default 8: bits per frame; must be at least 2.
- `DIV`, default 1: clock cycles per serial bit; must be at least 1. DIV=1 matches the detector, which consumes one bit per clock.
- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset (0 = reset).
- `data_in`  in  WIDTH  word to serialise; sampled only when the load is accepted.
- `load`  in  1  load request; accepted on a rising edge where `load`=1 and `ready`=1.
- `ready`  out  1  high only in IDLE.
- `w`  out  1  serial bit, MSB first; 0 whenever not in SHIFT.
- `bit_strobe`  out  1  high in the first cycle of every bit period.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse in the DONE state.

## Operation
- The FSM has three states:
  - IDLE → SHIFT on load acceptance.
  - SHIFT → DONE when the last bit period expires.
  - DONE → IDLE unconditionally.
- Load acceptance:
  - Captures `data_in` into the shift register.
  - Clears the bit counter (range 0..WIDTH-1) and the divide counter (range 0..DIV-1).
- In SHIFT:
  - `w` = shift_reg[WIDTH-1].
  - The divide counter increments every cycle.
  - When the divide counter reaches DIV-1: it wraps to 0, the register shifts left with 0 filled in, and the bit counter increments.
  - When the divide counter is at DIV-1 and the bit counter is at WIDTH-1, the next state is DONE instead.
- `bit_strobe` = (state==SHIFT) && (div_cnt==0).
- `load` while `ready`=0 is ignored and has no side effects; it is not queued.
- `load` held high continuously: the next word is accepted on the first IDLE edge after DONE.
- Reset mid-frame:
  - Immediately forces IDLE and clears the shift register and both counters.
  - `w`=0, `busy`=0, `done`=0, `bit_strobe`=0; the partial frame is discarded.
- Reset values: `ready`=1, `w`=0, `bit_strobe`=0, `busy`=0, `done`=0.
- All outputs are Moore outputs, decoded from registered state only; there are no combinational paths from `load` or `data_in` to any output.

## Timing
- Load accepted at edge k:
  - Cycles k+1 .. k+WIDTH·DIV: SHIFT. Bit i (i=0 is the MSB) is on `w` during cycles k+1+i·DIV .. k+(i+1)·DIV.
  - Cycle k+WIDTH·DIV+1: DONE (`done`=1, `w`=0, `ready`=0).
  - Cycle k+WIDTH·DIV+2: IDLE, `ready`=1.
- Minimum frame-to-frame spacing is WIDTH·DIV+2 cycles. This leaves at least two `w`=0 cycles between frames, which also resets the detector to its default state.
- DIV=1: `bit_strobe` is high for every SHIFT cycle.

## Structure
- Shared package `serial_src_pkg` holds:
  - State encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10. The unused code 2'b11 recovers to IDLE.
  - Counter-width constants derived with $clog2(WIDTH) and $clog2(DIV), the latter with a floor of 1 bit.
- One natural sub-module, `bit_timer`, provides:
  - The DIV prescaler, outputting `period_start` and `period_end`.
  - Synchronous clear, plus the same async active-low `Reset`.
- The shift register, bit counter and FSM stay in the top module.

## Test plan
- Reset: drive `Reset`=0 mid-cycle → outputs go immediately to `ready`=1, `w`=0, `busy`=0, `done`=0, `bit_strobe`=0.
- WIDTH=8, DIV=1, load 8'b1101_0000 at edge 0:
  - `w`=1,1,0,1,0,0,0,0 on cycles 1–8.
  - `done` on cycle 9; `ready` on cycle 10.
  - The downstream detector's `z` asserts once, one cycle after the fourth bit.
- DIV=4, load 8'hA5 at edge 0:
  - Each bit held 4 cycles.
  - `bit_strobe` on cycles 1,5,9,…,29.
  - `done` on cycle 33.
- Load ignored while busy: load 8'h0F, then pulse `load` with 8'hFF on cycle 3 → `w` still carries 0x0F; `done` on cycle 9 only.
- Reset during SHIFT (DIV=1, load 8'hFF, `Reset`=0 on cycle 3) → `w`=0 immediately. After release, a load of 8'h80 produces `w`=1 then seven 0s.
- `load` tied to 1 with 8'hC3 (DIV=1) → frames start on cycles 1, 11, 21. `w`=0 on the DONE and IDLE cycles between frames (e.g. 9–10).
